memory_read_ctrl_mc: RTL

Multi-channel linked-list frame reader between the packet buffer memory and NUM_CH egress consumers. Each channel walks a chain of blocks from a start address, following each block's footer next_idx until eop. Channels share one single-ported read interface through a round-robin arbiter. Each channel has its own output FIFO with ready/valid backpressure, abort, and a runaway-chain (loop) guard.

---
 rtl/memory_read_ctrl_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/memory_read_ctrl_mc.sv
// Multi-channel linked-list block reader: each channel walks a footer-linked chain,
// channels share one memory read port through a round-robin arbiter.
//
// state   | meaning
// S_IDLE  | waiting for start_i
// S_REQ   | requesting a block read (eligible while FIFO has room)
// S_WAIT  | read granted, data returns this cycle
// S_DONE  | frame complete, waiting for consumer to drain FIFO
// S_DRAIN | aborted with a read in flight, discarding the return
module memory_read_ctrl_mc #(
  parameter int NUM_CH        = 4,
  parameter int ADDR_W        = 12,
  parameter int BLOCK_BITS    = 512,
  parameter int CH_FIFO_DEPTH = 2,
  parameter int MAX_BLOCKS    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            start_i,
  input  logic [NUM_CH*ADDR_W-1:0]     start_addr_i,
  input  logic [NUM_CH-1:0]            abort_i,
  output logic [NUM_CH-1:0]            busy_o,
  output logic                         mem_re_o,
  output logic [ADDR_W-1:0]            mem_raddr_o,
  input  logic                         mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0]        mem_rdata_i,
  output logic [NUM_CH*BLOCK_BITS-1:0] data_o,
  output logic [NUM_CH-1:0]            data_valid_o,
  input  logic [NUM_CH-1:0]            data_ready_i,
  output logic [NUM_CH-1:0]            data_last_o,
  output logic [NUM_CH-1:0]            err_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(CH_FIFO_DEPTH);
  localparam int CNT_W = $clog2(CH_FIFO_DEPTH + 1);
  localparam int BLK_W = $clog2(MAX_BLOCKS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CH_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CH_W-1:0]          r_rr_ptr;
  logic [CH_W-1:0]          r_tag;
  logic                     r_tag_valid;
  logic                     r_rst_q;

  logic [NUM_CH-1:0]        w_elig;
  logic [NUM_CH*ADDR_W-1:0] w_addr_flat;
  logic                     w_gnt_vld;
  logic [CH_W-1:0]          w_gnt;
  logic [CH_W-1:0]          w_idx;
  logic [ADDR_W-1:0]        w_next_idx;
  logic                     w_eop;

  assign w_next_idx = mem_rdata_i[ADDR_W-1:0];
  assign w_eop      = mem_rdata_i[12];

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  always_comb begin
    mem_raddr_o = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_gnt_vld && (w_gnt == CH_W'(i))) mem_raddr_o = w_addr_flat[i*ADDR_W +: ADDR_W];
  end

  assign mem_re_o = w_gnt_vld;

  // Granted channel is the tag for the single-cycle read return.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_rr_ptr    <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_tag_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_tag    <= w_gnt;
        r_rr_ptr <= (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + CH_W'(1);
      end
      if (!r_rst_q && mem_rvalid_i) assert (r_tag_valid);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t                r_state;
    logic [ADDR_W-1:0]     r_next_addr;
    logic [BLK_W-1:0]      r_blk_left;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_err;
    logic [BLOCK_BITS-1:0] r_mem [CH_FIFO_DEPTH];
    logic [CH_FIFO_DEPTH-1:0] r_mem_last;
    logic w_own, w_ret, w_push, w_pop, w_flush, w_last, w_granted, w_nonempty;

    assign w_own      = r_tag_valid && (r_tag == CH_W'(g));
    assign w_ret      = mem_rvalid_i && w_own;
    assign w_push     = w_ret && (r_state == S_WAIT) && !abort_i[g];
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && data_ready_i[g];
    assign w_flush    = abort_i[g] && (r_state inside {S_REQ, S_WAIT, S_DONE});
    // Down-counter reaching zero means this is the final allowed block.
    assign w_last     = w_eop || (r_blk_left == '0);
    assign w_granted  = w_gnt_vld && (w_gnt == CH_W'(g));
    assign w_elig[g]  = (r_state == S_REQ) && (r_count < CNT_W'(CH_FIFO_DEPTH)) && !abort_i[g];

    assign w_addr_flat[g*ADDR_W +: ADDR_W]       = r_next_addr;
    assign busy_o[g]                             = (r_state != S_IDLE);
    assign data_valid_o[g]                       = w_nonempty;
    assign data_last_o[g]                        = w_nonempty && r_mem_last[r_rd_ptr];
    assign data_o[g*BLOCK_BITS +: BLOCK_BITS]    = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign err_o[g]                              = r_err;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state     <= S_IDLE;
        r_next_addr <= '0;
        r_blk_left  <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_err       <= 1'b0;
      end else begin
        r_err <= 1'b0;
        case (r_state)
          S_IDLE: if (start_i[g]) begin
            r_next_addr <= start_addr_i[g*ADDR_W +: ADDR_W];
            r_blk_left  <= BLK_W'(MAX_BLOCKS - 1);
            r_state     <= S_REQ;
          end
          S_REQ: begin
            if (abort_i[g])     r_state <= S_IDLE;
            else if (w_granted) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (abort_i[g]) r_state <= S_DRAIN;
            else if (w_ret) begin
              r_next_addr <= w_next_idx;
              r_blk_left  <= r_blk_left - BLK_W'(1);
              r_state     <= w_last ? S_DONE : S_REQ;
              r_err       <= w_last && !w_eop;
            end
          end
          S_DONE:  if (abort_i[g] || !w_nonempty) r_state <= S_IDLE;
          S_DRAIN: if (w_ret || !w_own) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase

        if (w_flush) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
          if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
          if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
          else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end

        if (w_push) assert (r_count < CNT_W'(CH_FIFO_DEPTH));
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= mem_rdata_i;
        r_mem_last[r_wr_ptr] <= w_last;
      end
    end
  end

endmodule
